// File: rtl/crc_pkg.sv
// Shared types and default sizing for the CRC frame sequencer.
// Optional compare feature is enabled with the CRC_CHECK_EN macro (see crc_stream_ctrl).
package crc_pkg;

  localparam int unsigned CRC_WCODE  = 4;
  localparam int unsigned CRC_WPOLY  = 5;
  localparam int unsigned CRC_MAXLEN = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/crc_coder.sv
// Combinational CRC step: folds one WCODE-bit data word into the running
// remainder. Each set data bit b XORs in the generator shifted by b, and only
// the low WPOLY-1 bits are kept.
module crc_coder #(
  parameter int unsigned WCODE = 4,
  parameter int unsigned WPOLY = 5
) (
  input  logic [WCODE-1:0] i_data,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [WPOLY-2:0] i_crc,
  output logic [WPOLY-2:0] o_crc
);

  // The leading generator term always lands above the kept remainder bits.
  logic unused_poly_msb;
  assign unused_poly_msb = i_poly[WPOLY-1];

  // Accumulate the shifted generator for every set data bit.
  always_comb begin
    o_crc = i_crc;
    for (int unsigned b = 0; b < WCODE; b++) begin
      if (i_data[b]) begin
        o_crc = o_crc ^ (i_poly[WPOLY-2:0] << b);
      end
    end
  end

endmodule

// File: rtl/crc_stream_ctrl.sv
// Frame-level sequencer around crc_coder: accepts i_len words over a
// valid/ready handshake, chains the remainder one step per accepted word and
// presents the final CRC on an output valid/ready handshake.
// Define CRC_CHECK_EN to add i_exp_crc / o_match comparison of the result.
module crc_stream_ctrl
  import crc_pkg::*;
#(
  parameter  int unsigned WCODE  = CRC_WCODE,
  parameter  int unsigned WPOLY  = CRC_WPOLY,
  parameter  int unsigned MAXLEN = CRC_MAXLEN,
  localparam int unsigned WCNT   = $clog2(MAXLEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WCNT-1:0]  i_len,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [WPOLY-2:0] i_init,
  input  logic [WCODE-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
`ifdef CRC_CHECK_EN
  input  logic [WPOLY-2:0] i_exp_crc,
  output logic             o_match,
`endif
  output logic             o_err_len
);

  state_t           state_q, state_d;
  logic [WPOLY-2:0] crc_q, crc_d;
  logic [WCNT-1:0]  cnt_q, cnt_d;
  logic [WPOLY-1:0] poly_q, poly_d;
  logic             err_q, err_d;
  logic [WPOLY-2:0] step_crc;
  logic             len_ok;
`ifdef CRC_CHECK_EN
  logic [WPOLY-2:0] exp_q, exp_d;
`endif

  crc_coder #(
    .WCODE (WCODE),
    .WPOLY (WPOLY)
  ) u_coder (
    .i_data (i_data),
    .i_poly (poly_q),
    .i_crc  (crc_q),
    .o_crc  (step_crc)
  );

  assign len_ok = (i_len != '0) && (i_len <= WCNT'(MAXLEN));

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      poly_q  <= '0;
      err_q   <= 1'b0;
`ifdef CRC_CHECK_EN
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      poly_q  <= poly_d;
      err_q   <= err_d;
`ifdef CRC_CHECK_EN
      exp_q   <= exp_d;
`endif
    end
  end

  // Next-state and datapath update: latch on start, step per accepted word.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    poly_d  = poly_q;
    err_d   = 1'b0;
`ifdef CRC_CHECK_EN
    exp_d   = exp_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (len_ok) begin
            poly_d  = i_poly;
            crc_d   = i_init;
            cnt_d   = i_len;
`ifdef CRC_CHECK_EN
            exp_d   = i_exp_crc;
`endif
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (i_valid) begin
          crc_d = step_crc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == WCNT'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    o_ready   = (state_q == S_RUN);
    o_valid   = (state_q == S_DONE);
    o_busy    = (state_q == S_RUN) || (state_q == S_DONE);
    o_crc     = (state_q == S_DONE) ? crc_q : '0;
    o_err_len = err_q;
`ifdef CRC_CHECK_EN
    o_match   = (state_q == S_DONE) && (crc_q == exp_q);
`endif
  end

endmodule

// File: tb/tb_crc_stream_ctrl.sv
// Self-checking bench for crc_stream_ctrl: directed vector table, hand-written
// reset/error/backpressure sequences and randomized frames against a
// polynomial-arithmetic reference model.
module tb_crc_stream_ctrl;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic [4:0] i_len;
  logic [4:0] i_poly;
  logic [3:0] i_init;
  logic [3:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] o_crc;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_err_len;
`ifdef CRC_CHECK_EN
  logic [3:0] i_exp_crc;
  logic       o_match;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  crc_stream_ctrl #(.WCODE(4), .WPOLY(5), .MAXLEN(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_poly    (i_poly),
    .i_init    (i_init),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_crc     (o_crc),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
`ifdef CRC_CHECK_EN
    .i_exp_crc (i_exp_crc),
    .o_match   (o_match),
`endif
    .o_err_len (o_err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  poly;
    logic [3:0]  init;
    logic [4:0]  len;
    logic [63:0] words;
    logic [3:0]  exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Remainder as polynomial arithmetic: each word d contributes d(x)*g(x) mod x^4.
  function automatic logic [3:0] ref_crc(input logic [4:0] poly, input logic [3:0] init,
                                         input int len, input logic [63:0] words);
    int r;
    int d;
    r = int'(init);
    for (int k = 0; k < len; k++) begin
      d = int'(words[k*4 +: 4]);
      for (int b = 0; b < 4; b++) begin
        if (((d >> b) & 1) == 1) r = r ^ ((int'(poly) << b) % 16);
      end
    end
    return 4'(r);
  endfunction

  // Entered and left at 1 time unit after a rising edge, DUT idle.
  task automatic do_frame(input logic [4:0] poly, input logic [3:0] init, input int len,
                          input logic [63:0] words, input bit gaps, input int rdy_dly,
                          input logic [3:0] exp, input logic [3:0] expc);
    int idx;
    int guard;
    check("idle_busy", 32'(o_busy), 32'd0);
    i_start = 1'b1;
    i_len   = 5'(len);
    i_poly  = poly;
    i_init  = init;
`ifdef CRC_CHECK_EN
    i_exp_crc = expc;
`endif
    @(posedge clk); #1;
    i_start = 1'b0;
    i_poly  = 5'($urandom);
    i_init  = 4'($urandom);
    i_len   = 5'($urandom);
`ifdef CRC_CHECK_EN
    i_exp_crc = 4'($urandom);
`endif
    check("start_ready", 32'(o_ready), 32'd1);
    check("start_no_err", 32'(o_err_len), 32'd0);
    idx = 0;
    guard = 0;
    while (idx < len && guard < 400) begin
      guard++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
        check("run_ready", 32'({o_ready, o_valid}), 32'b10);
        break;
      end
      i_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_data  = i_valid ? words[idx*4 +: 4] : 4'($urandom);
      i_start = 1'($urandom_range(0, 1));
      i_len   = 5'($urandom_range(1, 16));
      @(posedge clk); #1;
      if (i_valid) idx++;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    if (idx < len) check("accept_budget", 32'(idx), 32'(len));
    check("done_valid", 32'(o_valid), 32'd1);
    check("done_crc", 32'(o_crc), 32'(exp));
    check("done_ready", 32'(o_ready), 32'd0);
`ifdef CRC_CHECK_EN
    check("done_match", 32'(o_match), 32'(expc == exp));
`endif
    for (int c = 0; c < rdy_dly; c++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_crc", 32'(o_crc), 32'(exp));
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("post_valid", 32'(o_valid), 32'd0);
    check("post_crc", 32'(o_crc), 32'd0);
    check("post_busy", 32'(o_busy), 32'd0);
`ifdef CRC_CHECK_EN
    check("post_match", 32'(o_match), 32'd0);
`endif
  endtask

  task automatic err_case(input int len);
    i_start = 1'b1;
    i_len   = 5'(len);
    @(posedge clk); #1;
    i_start = 1'b0;
    check("err_pulse", 32'(o_err_len), 32'd1);
    check("err_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    check("err_single", 32'(o_err_len), 32'd0);
    check("err_idle", 32'({o_busy, o_ready}), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({o_ready, o_valid, o_busy, o_err_len, o_crc}), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [4:0]  rp;
    logic [3:0]  ri;
    int          rl;
    logic [63:0] rw;

    vecs[0] = '{poly: 5'b10011, init: 4'h0, len: 5'd2,  words: 64'h11,  exp: 4'h0};
    vecs[1] = '{poly: 5'b10011, init: 4'hA, len: 5'd1,  words: 64'h0,   exp: 4'hA};
    vecs[2] = '{poly: 5'b10011, init: 4'h0, len: 5'd1,  words: 64'h8,   exp: 4'h8};
    vecs[3] = '{poly: 5'b10011, init: 4'h0, len: 5'd1,  words: 64'h1,   exp: 4'h3};
    vecs[4] = '{poly: 5'b10011, init: 4'h5, len: 5'd16, words: 64'hFFFF_FFFF_FFFF_FFFF, exp: 4'h5};
    vecs[5] = '{poly: 5'b11001, init: 4'h0, len: 5'd3,  words: 64'h421, exp: 4'hF};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_len   = '0;
    i_poly  = '0;
    i_init  = '0;
    i_data  = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
`ifdef CRC_CHECK_EN
    i_exp_crc = '0;
`endif
    #12;
    check_all_zero("reset_outputs");
`ifdef CRC_CHECK_EN
    check("reset_match", 32'(o_match), 32'd0);
`endif
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: first entry also exercises 5 cycles of output backpressure.
    for (int i = 0; i < 6; i++) begin
      check("model_vs_table", 32'(ref_crc(vecs[i].poly, vecs[i].init, int'(vecs[i].len), vecs[i].words)),
            32'(vecs[i].exp));
      do_frame(vecs[i].poly, vecs[i].init, int'(vecs[i].len), vecs[i].words,
               (i % 2) == 1, (i == 0) ? 5 : i % 3, vecs[i].exp, vecs[i].exp);
    end

    // Invalid lengths are rejected with a one-cycle pulse.
    err_case(0);
    err_case(17);

    // Asynchronous reset after 1 of 3 words, then a clean frame.
    i_start = 1'b1;
    i_len   = 5'd3;
    i_poly  = 5'b10011;
    i_init  = 4'h0;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_valid = 1'b1;
    i_data  = 4'h1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd1);
    #3 i_rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #2;
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_reset");
    do_frame(5'b10011, 4'h0, 2, 64'h11, 1'b0, 0, 4'h0, 4'h0);

`ifdef CRC_CHECK_EN
    do_frame(5'b10011, 4'h0, 2, 64'h11, 1'b0, 1, 4'h0, 4'h5);
`endif

    // Randomized frames against the reference model.
    for (int n = 0; n < 25; n++) begin
      rp = 5'($urandom);
      ri = 4'($urandom);
      rl = $urandom_range(1, 16);
      rw = {32'($urandom), 32'($urandom)};
      do_frame(rp, ri, rl, rw, 1'b1, $urandom_range(0, 3), ref_crc(rp, ri, rl, rw),
               (n % 3 == 0) ? 4'($urandom) : ref_crc(rp, ri, rl, rw));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_stream_ctrl.md
Name: crc_stream_ctrl

Overview:
Frame-level sequencer for the combinational CRC step used in the ALU datapath. It accepts a frame of WCODE-bit words over a valid/ready handshake and chains the running remainder through one CRC step per accepted word. It presents the final WPOLY-1-bit CRC on an output valid/ready handshake. It sits between the operand source and the result register bank.

Parameters:
WCODE, 4, data word width (bits)
WPOLY, 5, generator polynomial width; CRC width = WPOLY-1
MAXLEN, 16, maximum words per frame
WCNT, $clog2(MAXLEN+1), derived (localparam), length/counter width

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  frame start request, sampled only in S_IDLE
i_len  input  WCNT  frame length in words, sampled with i_start
i_poly  input  WPOLY  generator polynomial, sampled with i_start
i_init  input  WPOLY-1  CRC seed, sampled with i_start
i_data  input  WCODE  data word
i_valid  input  1  i_data valid
o_ready  output  1  controller accepts a word
o_crc  output  WPOLY-1  final CRC
o_valid  output  1  o_crc valid
i_ready  input  1  downstream accepts o_crc
o_busy  output  1  frame in progress (S_RUN or S_DONE)
o_err_len  output  1  one-cycle pulse: start rejected, i_len==0 or i_len>MAXLEN

Behaviour:
- Reset, asynchronous on i_rst_n low: state S_IDLE; crc_reg, cnt, poly_reg all 0; o_ready=0, o_valid=0, o_busy=0, o_err_len=0, o_crc=0. A reset mid-frame discards the partial CRC. No output is produced for the aborted frame.
- Step function: step(crc,d) = crc_coder output with i_data=d, i_poly=poly_reg, i_crc=crc. The function is purely combinational.
- S_IDLE: o_ready=0, o_valid=0.
  - i_start with 1<=i_len<=MAXLEN: latch poly_reg=i_poly, crc_reg=i_init, cnt=i_len, then go to S_RUN.
  - i_start with an invalid i_len: o_err_len=1 for exactly the next cycle; remain in S_IDLE.
- S_RUN: o_ready=1, o_busy=1.
  - On i_valid&&o_ready: crc_reg<=step(crc_reg,i_data) and cnt<=cnt-1.
  - When the accepted word has cnt==1, go to S_DONE.
  - With i_valid=0: hold all state, no timeout.
- S_DONE: o_ready=0, o_valid=1, o_crc=crc_reg, held stable while i_ready=0.
  - On o_valid&&i_ready: go to S_IDLE. o_valid drops the next cycle.
- o_crc is registered (driven from crc_reg). It reads 0 outside S_DONE.
- Throughput: 1 word/cycle in S_RUN.
- Latency: o_valid rises the cycle after the last word is accepted.
- Minimum frame-to-frame gap: one S_IDLE cycle (i_start is not sampled in S_DONE).
- i_start outside S_IDLE is ignored. Changes to i_poly, i_init or i_len after the start cycle have no effect.
- cnt never wraps: a frame of MAXLEN words is legal, and cnt reaches 0 only on transition to S_DONE.

Optional Feature:
Macro CRC_CHECK_EN.
- Defined: adds input i_exp_crc [WPOLY-2:0], sampled with i_start into exp_reg, and output o_match (1 bit).
  - o_match = (crc_reg==exp_reg) while o_valid=1, otherwise 0.
  - o_match resets to 0.
- Undefined: i_exp_crc, o_match and exp_reg do not exist. All other behaviour is identical.

Decomposition:
- Package crc_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_RUN, S_DONE}
  - default constants CRC_WCODE=4, CRC_WPOLY=5, CRC_MAXLEN=16
- One sub-module: crc_coder, instantiated once as the combinational step with WCODE/WPOLY passed through. The controller contains no CRC arithmetic of its own.

Test Plan:
1. poly=5'b10011, init=0, len=2, words 4'h1 then 4'h1 -> after first accept crc_reg=4'h3; o_valid one cycle after second accept with o_crc=4'h0.
2. poly=5'b10011, init=4'hA, len=1, word 4'h0 -> o_crc=4'hA. Then repeat with init=0, word 4'h8 -> o_crc=4'h8.
3. Backpressure:
   - i_valid toggling 1/0 in S_RUN -> CRC depends only on accepted words.
   - i_ready=0 for 5 cycles in S_DONE -> o_valid and o_crc stable, then S_IDLE after handshake.
4. i_len=0 and i_len=17 with i_start -> o_err_len single-cycle pulse, o_busy stays 0. i_len=16 -> exactly 16 accepts, then o_valid.
5. i_rst_n low after 1 of 3 words -> all outputs 0 asynchronously. A new frame (test 1 stimulus) then gives o_crc=4'h0. i_start pulsed during S_RUN is ignored.
6. With CRC_CHECK_EN, test 1 stimulus and i_exp_crc=4'h0 -> o_match=1. With i_exp_crc=4'h5 -> o_match=0.
